// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that grants one requester at a time a burst of up to BURST serial bits,
// feeding the grantee's bits through a shared six-state Moore sequence detector.
module seq_detect_scheduler #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned BURST = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          w,
   output logic [NREQ-1:0]          grant,
   output logic [$clog2(NREQ)-1:0]  owner,
   output logic                     busy,
   output logic                     z,
   output logic                     done
);

   localparam int unsigned OW = $clog2(NREQ);
   localparam int unsigned CW = $clog2(BURST + 1);

   typedef enum logic [1:0] {StIdle, StRun, StRelease} state_e;
   typedef enum logic [2:0] {DetA, DetB, DetC, DetD, DetE, DetF} det_e;

   state_e          state_q, state_d;
   det_e            det_q, det_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   last_q, last_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            z_q, z_d;
   logic [OW-1:0]   win;

   function automatic det_e det_next(input det_e s, input logic b);
      det_e n;
      unique case (s)
         DetA:    n = b ? DetA : DetB;
         DetB:    n = b ? DetD : DetC;
         DetC:    n = b ? DetD : DetE;
         DetD:    n = b ? DetA : DetF;
         DetE:    n = b ? DetD : DetE;
         DetF:    n = b ? DetD : DetC;
         default: n = DetA;
      endcase
      return n;
   endfunction

   // Search starts just after the last grantee and wraps, so every requester gets a turn.
   always_comb begin
      logic          found;
      int unsigned   idx;
      logic [OW-1:0] idx_t;
      found = 1'b0;
      win   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx   = (32'(last_q) + k) % NREQ;
         idx_t = OW'(idx);
         if (!found && req[idx_t]) begin
            found = 1'b1;
            win   = idx_t;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      det_d   = det_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            grant_d = '0;
            if (|req) begin
               state_d = StRun;
               owner_d = win;
               grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win;
               cnt_d   = '0;
               det_d   = DetA;
            end
         end
         StRun: begin
            if (req[owner_q]) begin
               det_d = det_next(det_q, w[owner_q]);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(BURST - 1)) begin
                  state_d = StRelease;
                  last_d  = owner_q;
                  grant_d = '0;
                  det_d   = DetA;
               end
            end else begin
               // Requester withdrew: abort without consuming a bit.
               state_d = StRelease;
               last_d  = owner_q;
               grant_d = '0;
               det_d   = DetA;
            end
         end
         StRelease: begin
            state_d = StIdle;
            grant_d = '0;
            det_d   = DetA;
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
            det_d   = DetA;
         end
      endcase
      z_d = (state_d == StRun) && ((det_d == DetE) || (det_d == DetF));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         det_q   <= DetA;
         owner_q <= '0;
         last_q  <= OW'(NREQ - 1);
         grant_q <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         det_q   <= det_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
      end
   end

   assign grant = grant_q;
   assign owner = owner_q;
   assign busy  = (state_q == StRun);
   assign done  = (state_q == StRelease);
   assign z     = z_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a behavioural model of grants, bursts and the detector.
module tb_seq_detect_scheduler;

   localparam int NREQ  = 4;
   localparam int BURST = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] w = '0;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       busy, z, done;

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 granted, 2 release; detector states 0..5 stand for A..F.
   int m_phase, m_owner, m_last, m_bits, m_det;
   int det_tab [6][2];

   always #5 clk = ~clk;

   seq_detect_scheduler #(.NREQ(NREQ), .BURST(BURST)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .w     (w),
      .grant (grant),
      .owner (owner),
      .busy  (busy),
      .z     (z),
      .done  (done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [3:0] r);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (last + k) % NREQ;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_bits  = 0;
      m_det   = 0;
   endtask

   task automatic model_edge();
      case (m_phase)
         0: if (req != 0) begin
            m_owner = rr_pick(m_last, req);
            m_phase = 1;
            m_bits  = 0;
            m_det   = 0;
         end
         1: if (req[m_owner]) begin
            m_det = det_tab[m_det][w[m_owner]];
            m_bits++;
            if (m_bits == BURST) begin
               m_phase = 2;
               m_last  = m_owner;
            end
         end else begin
            m_phase = 2;
            m_last  = m_owner;
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic check_outputs();
      chk("grant", grant, (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
      chk("owner", owner, m_owner);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("z", z, (m_phase == 1) && (m_det == 4 || m_det == 5));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic run_until_idle();
      for (int i = 0; i < BURST + 4 && m_phase != 0; i++) tick();
      chk("drain_busy", busy, 0);
   endtask

   initial begin
      det_tab = '{'{1, 0}, '{2, 3}, '{4, 3}, '{5, 0}, '{4, 3}, '{2, 3}};

      // Asynchronous reset before any clock edge.
      #1 reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      reset = 1'b0;

      // Idle hold.
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_grant", grant, 0);
         chk("idle_busy", busy, 0);
         chk("idle_z", z, 0);
         chk("idle_done", done, 0);
      end

      // Detector walk A->B->C->E, then D.
      req = 4'b0001;
      tick();
      chk("det_grant", grant, 4'b0001);
      for (int i = 0; i < 3; i++) tick();
      chk("det_z_E", z, 1);
      w = 4'b0001;
      tick();
      chk("det_z_D", z, 0);
      req = '0;
      run_until_idle();

      // Fairness from a fresh reset: four grants of 8 cycles, 10 cycles apart.
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
      req = 4'b1111;
      for (int i = 1; i <= 40; i++) begin
         w = 4'($urandom);
         tick();
         chk("fair_grant", grant, ((i - 1) % 10 < 8) ? (32'd1 << ((i - 1) / 10)) : 32'd0);
      end
      req = '0;
      run_until_idle();

      // Abort after three bits.
      req = 4'b0010;
      tick();
      chk("abort_grant", grant, 4'b0010);
      for (int i = 0; i < 3; i++) begin
         w = 4'($urandom);
         tick();
      end
      req = '0;
      tick();
      chk("abort_done", done, 1);
      chk("abort_grant0", grant, 0);
      tick();
      chk("abort_z", z, 0);
      chk("abort_done0", done, 0);

      // Wrap-around of the round-robin pointer.
      req = 4'b1000;
      tick();
      chk("wrap_g3", grant, 4'b1000);
      run_until_idle();
      req = 4'b1001;
      tick();
      chk("wrap_g0", grant, 4'b0001);
      run_until_idle();
      req = 4'b1000;
      tick();
      run_until_idle();
      tick();
      chk("wrap_g3_again", grant, 4'b1000);
      req = '0;
      run_until_idle();

      // Reset in the fifth RUN cycle of requester 2.
      req = 4'b0100;
      tick();
      chk("mid_grant", grant, 4'b0100);
      for (int i = 0; i < 4; i++) begin
         w = 4'($urandom);
         tick();
      end
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_z", z, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      req = 4'b0110;
      tick();
      chk("post_rst_grant", grant, 4'b0010);
      req = '0;
      run_until_idle();

      // Randomized traffic with mostly stable request levels.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(7) == 0) req = 4'($urandom);
         w = 4'($urandom);
         tick();
      end
      req = '0;
      run_until_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
